// File: rtl/pu_conv_scheduler_pkg.sv
// Shared constants for the PU convolution loop sequencer:
// layer-type codes, FSM state encoding and default widths.
package pu_conv_scheduler_pkg;

   localparam int DEF_LAYER_PARAM_WIDTH = 10;
   localparam int DEF_PAD_WIDTH         = 3;
   localparam int DEF_STRIDE_SIZE_W     = 3;
   localparam int DEF_L_TYPE_WIDTH      = 2;

   localparam int L_TYPE_CONV = 0;
   localparam int L_TYPE_IP   = 1;
   localparam int L_TYPE_NORM = 2;
   localparam int L_TYPE_RSVD = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT_ROW,
      S_WB,
      S_NEXT,
      S_DONE
   } state_t;

endpackage

// File: rtl/pu_row_window.sv
// Combinational row-window geometry for one output row.
// Ports:
//   i_top        signed top kernel row in image coords
//   i_kh/i_ih    kernel / image height (value-1)
//   i_pad        vertical zero padding
//   i_stride     effective stride (never 0)
//   o_pad_top    kernel rows above image, saturated
//   o_pad_bot    kernel rows below image, saturated
//   o_last_row   next window would leave padded image
module pu_row_window
   import pu_conv_scheduler_pkg::*;
#(
   parameter int LAYER_PARAM_WIDTH = DEF_LAYER_PARAM_WIDTH,
   parameter int PAD_WIDTH         = DEF_PAD_WIDTH,
   parameter int STRIDE_SIZE_W     = DEF_STRIDE_SIZE_W
) (
   input  logic signed [LAYER_PARAM_WIDTH+1:0] i_top,
   input  logic [LAYER_PARAM_WIDTH-1:0]        i_kh,
   input  logic [LAYER_PARAM_WIDTH-1:0]        i_ih,
   input  logic [PAD_WIDTH-1:0]                i_pad,
   input  logic [STRIDE_SIZE_W-1:0]            i_stride,
   output logic [PAD_WIDTH-1:0]                o_pad_top,
   output logic [PAD_WIDTH-1:0]                o_pad_bot,
   output logic                                o_last_row
);

   localparam int LW = LAYER_PARAM_WIDTH;
   localparam int AW = LW + 4;

   localparam logic signed [AW-1:0] ZERO = '0;
   localparam logic signed [AW-1:0] ONE  = AW'(1);
   localparam logic signed [AW-1:0] PMAX =
      AW'((1 << PAD_WIDTH) - 1);

   logic signed [AW-1:0] w_top;
   logic signed [AW-1:0] w_k;
   logic signed [AW-1:0] w_h;
   logic signed [AW-1:0] w_pad;
   logic signed [AW-1:0] w_str;
   logic signed [AW-1:0] w_neg;
   logic signed [AW-1:0] w_bot;
   logic signed [AW-1:0] w_nxt_end;
   logic signed [AW-1:0] w_lim;

   assign w_top = {{(AW-LW-2){i_top[LW+1]}}, i_top};
   assign w_k   = $signed({{(AW-LW){1'b0}}, i_kh}) + ONE;
   assign w_h   = $signed({{(AW-LW){1'b0}}, i_ih}) + ONE;
   assign w_pad =
      $signed({{(AW-PAD_WIDTH){1'b0}}, i_pad});
   assign w_str =
      $signed({{(AW-STRIDE_SIZE_W){1'b0}}, i_stride});

   assign w_neg = ZERO - w_top;
   assign w_bot = w_top + w_k - w_h;

   // Window bottom after stepping, compared with the
   // last padded row; the first row is always issued.
   assign w_nxt_end = w_top + w_str + w_k;
   assign w_lim     = w_h + w_pad;

   always_comb begin
      o_pad_top = '0;
      if (w_neg > PMAX)
         o_pad_top = PMAX[PAD_WIDTH-1:0];
      else if (w_neg > ZERO)
         o_pad_top = w_neg[PAD_WIDTH-1:0];
   end

   always_comb begin
      o_pad_bot = '0;
      if (w_bot > PMAX)
         o_pad_bot = PMAX[PAD_WIDTH-1:0];
      else if (w_bot > ZERO)
         o_pad_bot = w_bot[PAD_WIDTH-1:0];
   end

   assign o_last_row = (w_nxt_end > w_lim);

endmodule

// File: rtl/pu_conv_scheduler.sv
// Per-layer loop sequencer: walks oc -> row -> ic and
// issues one row command per step to vectorgen.
// Ports:
//   i_clk, i_reset           clock, async active-low reset
//   i_cfg_*, o_cfg_ready     layer config handshake
//   o_row_*                  row command (valid on row_start)
//   i_row_done               vectorgen finished the row
//   o_wb_req, i_wb_ready     writeback handshake
//   o_layer_done, o_cfg_err  completion pulse, sticky error
module pu_conv_scheduler
   import pu_conv_scheduler_pkg::*;
#(
   parameter int LAYER_PARAM_WIDTH = DEF_LAYER_PARAM_WIDTH,
   parameter int PAD_WIDTH         = DEF_PAD_WIDTH,
   parameter int STRIDE_SIZE_W     = DEF_STRIDE_SIZE_W,
   parameter int L_TYPE_WIDTH      = DEF_L_TYPE_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_cfg_valid,
   output logic                         o_cfg_ready,
   input  logic [L_TYPE_WIDTH-1:0]      i_cfg_l_type,
   input  logic [LAYER_PARAM_WIDTH-1:0] i_cfg_ic,
   input  logic [LAYER_PARAM_WIDTH-1:0] i_cfg_oc,
   input  logic [LAYER_PARAM_WIDTH-1:0] i_cfg_ih,
   input  logic [LAYER_PARAM_WIDTH-1:0] i_cfg_kh,
   input  logic [PAD_WIDTH-1:0]         i_cfg_pad,
   input  logic [STRIDE_SIZE_W-1:0]     i_cfg_stride,
   output logic                         o_row_start,
   output logic [LAYER_PARAM_WIDTH-1:0] o_row_oc,
   output logic [LAYER_PARAM_WIDTH-1:0] o_row_ic,
   output logic [LAYER_PARAM_WIDTH-1:0] o_row_idx,
   output logic [PAD_WIDTH-1:0]         o_row_pad_top,
   output logic [PAD_WIDTH-1:0]         o_row_pad_bot,
   output logic                         o_row_first_ic,
   output logic                         o_row_last_ic,
   input  logic                         i_row_done,
   output logic                         o_wb_req,
   input  logic                         i_wb_ready,
   output logic                         o_layer_done,
   output logic                         o_cfg_err
);

   localparam int LW = LAYER_PARAM_WIDTH;
   localparam int TW = LW + 2;

   localparam logic [L_TYPE_WIDTH-1:0] LT_IP =
      L_TYPE_WIDTH'(L_TYPE_IP);
   localparam logic [L_TYPE_WIDTH-1:0] LT_NORM =
      L_TYPE_WIDTH'(L_TYPE_NORM);
   localparam logic [L_TYPE_WIDTH-1:0] LT_RSVD =
      L_TYPE_WIDTH'(L_TYPE_RSVD);

   state_t r_state;
   state_t w_next;

   logic [L_TYPE_WIDTH-1:0]  r_l_type;
   logic [LW-1:0]            r_ic_cfg;
   logic [LW-1:0]            r_oc_cfg;
   logic [LW-1:0]            r_ih;
   logic [LW-1:0]            r_kh;
   logic [PAD_WIDTH-1:0]     r_pad;
   logic [STRIDE_SIZE_W-1:0] r_stride_raw;

   logic [LW-1:0]            r_ic_max;
   logic [STRIDE_SIZE_W-1:0] r_stride;
   logic [LW-1:0]            r_oc;
   logic [LW-1:0]            r_ic;
   logic [LW-1:0]            r_row;
   // Top kernel row; one guard bit beyond sign so that
   // ih+pad is representable at the largest image size.
   logic signed [TW-1:0]     r_top;
   logic                     r_err;

   logic                 w_is_ip;
   logic                 w_is_norm;
   logic                 w_is_rsvd;
   logic                 w_ic_more;
   logic                 w_oc_last;
   logic                 w_last_row;
   logic                 w_row_wrap;
   logic                 w_active;
   logic [PAD_WIDTH-1:0] w_pad_top;
   logic [PAD_WIDTH-1:0] w_pad_bot;
   logic signed [TW-1:0] w_top_init;
   logic signed [TW-1:0] w_stride_ext;

   assign w_is_ip   = (r_l_type == LT_IP);
   assign w_is_norm = (r_l_type == LT_NORM);
   assign w_is_rsvd = (r_l_type == LT_RSVD);
   assign w_ic_more = (r_ic < r_ic_max);
   assign w_oc_last = (r_oc >= r_oc_cfg);
   // Innerproduct has a single row per oc.
   assign w_row_wrap = w_is_ip | w_last_row;

   assign w_top_init =
      -$signed({{(TW-PAD_WIDTH){1'b0}}, r_pad});
   assign w_stride_ext =
      $signed({{(TW-STRIDE_SIZE_W){1'b0}}, r_stride});

   pu_row_window #(
      .LAYER_PARAM_WIDTH(LW),
      .PAD_WIDTH        (PAD_WIDTH),
      .STRIDE_SIZE_W    (STRIDE_SIZE_W)
   ) u_win (
      .i_top     (r_top),
      .i_kh      (r_kh),
      .i_ih      (r_ih),
      .i_pad     (r_pad),
      .i_stride  (r_stride),
      .o_pad_top (w_pad_top),
      .o_pad_bot (w_pad_bot),
      .o_last_row(w_last_row)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_cfg_ready  = 1'b0;
      o_row_start  = 1'b0;
      o_wb_req     = 1'b0;
      o_layer_done = 1'b0;
      w_active     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            o_cfg_ready = 1'b1;
            if (i_cfg_valid)
               w_next = S_LOAD;
         end
         S_LOAD: begin
            w_next = w_is_rsvd ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            o_row_start = 1'b1;
            w_active    = 1'b1;
            w_next      = S_WAIT_ROW;
         end
         S_WAIT_ROW: begin
            w_active = 1'b1;
            if (i_row_done)
               w_next = w_ic_more ? S_ISSUE : S_WB;
         end
         S_WB: begin
            o_wb_req = 1'b1;
            if (i_wb_ready)
               w_next = S_NEXT;
         end
         S_NEXT: begin
            if (w_row_wrap && w_oc_last)
               w_next = S_DONE;
            else
               w_next = S_ISSUE;
         end
         S_DONE: begin
            o_layer_done = 1'b1;
            w_next       = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_l_type     <= '0;
         r_ic_cfg     <= '0;
         r_oc_cfg     <= '0;
         r_ih         <= '0;
         r_kh         <= '0;
         r_pad        <= '0;
         r_stride_raw <= '0;
         r_ic_max     <= '0;
         r_stride     <= '0;
         r_oc         <= '0;
         r_ic         <= '0;
         r_row        <= '0;
         r_top        <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cfg_valid) begin
                  r_l_type     <= i_cfg_l_type;
                  r_ic_cfg     <= i_cfg_ic;
                  r_oc_cfg     <= i_cfg_oc;
                  r_ih         <= i_cfg_ih;
                  r_kh         <= i_cfg_kh;
                  r_pad        <= i_cfg_pad;
                  r_stride_raw <= i_cfg_stride;
                  r_err        <= 1'b0;
               end
            end
            S_LOAD: begin
               // Norm layers make a single ic pass.
               r_ic_max <= w_is_norm ? '0 : r_ic_cfg;
               r_stride <= (r_stride_raw == '0)
                  ? STRIDE_SIZE_W'(1) : r_stride_raw;
               r_top    <= w_top_init;
               r_oc     <= '0;
               r_ic     <= '0;
               r_row    <= '0;
               if (w_is_rsvd)
                  r_err <= 1'b1;
            end
            S_WAIT_ROW: begin
               if (i_row_done && w_ic_more)
                  r_ic <= r_ic + 1'b1;
            end
            S_NEXT: begin
               r_ic <= '0;
               if (w_row_wrap) begin
                  r_top <= w_top_init;
                  r_row <= '0;
                  if (!w_oc_last)
                     r_oc <= r_oc + 1'b1;
               end else begin
                  r_top <= r_top + w_stride_ext;
                  r_row <= r_row + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Row fields are only meaningful around a command.
   assign o_row_oc  = w_active ? r_oc  : '0;
   assign o_row_ic  = w_active ? r_ic  : '0;
   assign o_row_idx = w_active ? r_row : '0;
   assign o_row_pad_top =
      (w_active && !w_is_ip) ? w_pad_top : '0;
   assign o_row_pad_bot =
      (w_active && !w_is_ip) ? w_pad_bot : '0;
   assign o_row_first_ic = w_active && (r_ic == '0);
   assign o_row_last_ic  = w_active && (r_ic == r_ic_max);
   assign o_cfg_err = r_err;

endmodule

// File: tb/tb_pu_conv_scheduler.sv
// Directed bench for pu_conv_scheduler.
// Responds to row_start / wb_req and checks the row stream.
module tb_pu_conv_scheduler;

   localparam int LW = 10;
   localparam int PW = 3;
   localparam int SW = 3;
   localparam int TW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [TW-1:0] cfg_l_type = '0;
   logic [LW-1:0] cfg_ic = '0;
   logic [LW-1:0] cfg_oc = '0;
   logic [LW-1:0] cfg_ih = '0;
   logic [LW-1:0] cfg_kh = '0;
   logic [PW-1:0] cfg_pad = '0;
   logic [SW-1:0] cfg_stride = '0;
   logic          row_start;
   logic [LW-1:0] row_oc;
   logic [LW-1:0] row_ic;
   logic [LW-1:0] row_idx;
   logic [PW-1:0] row_pad_top;
   logic [PW-1:0] row_pad_bot;
   logic          row_first_ic;
   logic          row_last_ic;
   logic          row_done = 1'b0;
   logic          wb_req;
   logic          wb_ready = 1'b0;
   logic          layer_done;
   logic          cfg_err;

   always #5 clk = ~clk;

   pu_conv_scheduler dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_cfg_valid   (cfg_valid),
      .o_cfg_ready   (cfg_ready),
      .i_cfg_l_type  (cfg_l_type),
      .i_cfg_ic      (cfg_ic),
      .i_cfg_oc      (cfg_oc),
      .i_cfg_ih      (cfg_ih),
      .i_cfg_kh      (cfg_kh),
      .i_cfg_pad     (cfg_pad),
      .i_cfg_stride  (cfg_stride),
      .o_row_start   (row_start),
      .o_row_oc      (row_oc),
      .o_row_ic      (row_ic),
      .o_row_idx     (row_idx),
      .o_row_pad_top (row_pad_top),
      .o_row_pad_bot (row_pad_bot),
      .o_row_first_ic(row_first_ic),
      .o_row_last_ic (row_last_ic),
      .i_row_done    (row_done),
      .o_wb_req      (wb_req),
      .i_wb_ready    (wb_ready),
      .o_layer_done  (layer_done),
      .o_cfg_err     (cfg_err)
   );

   int total = 0;
   int bad   = 0;
   int n_rs, n_wb, n_done, n_wbcyc, n_clash;

   logic [LW-1:0] rec_idx [64];
   logic [LW-1:0] rec_oc  [64];
   logic [LW-1:0] rec_ic  [64];
   logic [PW-1:0] rec_pt  [64];
   logic [PW-1:0] rec_pb  [64];
   logic          rec_fst [64];
   logic          rec_lst [64];

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cfg(input int t, input int ic,
                           input int oc, input int ih,
                           input int kh, input int pad,
                           input int st);
      int n;
      n = 0;
      while (!cfg_ready && n < 20) begin
         step();
         n++;
      end
      cfg_l_type = TW'(t);
      cfg_ic     = LW'(ic);
      cfg_oc     = LW'(oc);
      cfg_ih     = LW'(ih);
      cfg_kh     = LW'(kh);
      cfg_pad    = PW'(pad);
      cfg_stride = SW'(st);
      cfg_valid  = 1'b1;
      step();
      cfg_valid  = 1'b0;
   endtask

   // Plays vectorgen (row_done 2 cycles after row_start)
   // and the writeback sink (ready after wb_lat cycles).
   task automatic run_layer(input int wb_lat,
                            input bit spur,
                            input int maxcyc);
      int rd;
      int wbc;
      bit pwb;
      n_rs = 0; n_wb = 0; n_done = 0;
      n_wbcyc = 0; n_clash = 0;
      rd = 0; wbc = 0; pwb = 1'b0;
      for (int c = 0; c < maxcyc; c++) begin
         row_done = 1'b0;
         if (row_start) begin
            if (n_rs < 64) begin
               rec_idx[n_rs] = row_idx;
               rec_oc[n_rs]  = row_oc;
               rec_ic[n_rs]  = row_ic;
               rec_pt[n_rs]  = row_pad_top;
               rec_pb[n_rs]  = row_pad_bot;
               rec_fst[n_rs] = row_first_ic;
               rec_lst[n_rs] = row_last_ic;
            end
            n_rs++;
            rd = 2;
         end else if (rd > 0) begin
            rd--;
            if (rd == 0) row_done = 1'b1;
         end
         if (wb_req) begin
            if (!pwb) begin
               n_wb++;
               wbc = 0;
            end
            n_wbcyc++;
            if (row_start) n_clash++;
            wb_ready = (wbc >= wb_lat);
            if (spur && wbc == 3) row_done = 1'b1;
            wbc++;
         end else begin
            wb_ready = 1'b0;
         end
         pwb = wb_req;
         if (layer_done) n_done++;
         if (n_done != 0) break;
         step();
      end
      row_done = 1'b0;
      wb_ready = 1'b0;
   endtask

   initial begin
      logic [LW-1:0] agg;

      #2;
      chk("rst_ready", cfg_ready, 1);
      chk("rst_ctl",
          {row_start, wb_req, layer_done, cfg_err,
           row_first_ic, row_last_ic}, 0);
      chk("rst_row",
          {row_oc, row_ic, row_idx,
           row_pad_top, row_pad_bot}, 0);
      #12 rst_n = 1'b1;
      step();

      // T1: conv, 2 ic, 1 oc, H=4, K=2
      send_cfg(0, 1, 0, 3, 1, 0, 1);
      chk("t1_ready_drop", cfg_ready, 0);
      chk("t1_no_rs_load", row_start, 0);
      step();
      chk("t1_lat_rs", row_start, 1);
      chk("t1_first0", {row_first_ic, row_last_ic}, 2);
      run_layer(0, 1'b0, 300);
      chk("t1_done", n_done, 1);
      chk("t1_nrs", n_rs, 6);
      chk("t1_nwb", n_wb, 3);
      chk("t1_wbcyc", n_wbcyc, 3);
      chk("t1_ic1", rec_ic[1], 1);
      chk("t1_last1", {rec_fst[1], rec_lst[1]}, 1);
      chk("t1_first2", rec_fst[2], 1);
      chk("t1_idx2", rec_idx[2], 1);
      chk("t1_idx5", rec_idx[5], 2);
      chk("t1_pb5", rec_pb[5], 0);

      // T2: conv H=5, K=3, pad=1, stride=2
      send_cfg(0, 0, 0, 4, 2, 1, 2);
      run_layer(0, 1'b0, 300);
      chk("t2_done", n_done, 1);
      chk("t2_nrs", n_rs, 3);
      chk("t2_idx", {rec_idx[0], rec_idx[1], rec_idx[2]},
          {10'd0, 10'd1, 10'd2});
      chk("t2_ptop", {rec_pt[0], rec_pt[1], rec_pt[2]},
          {3'd1, 3'd0, 3'd0});
      chk("t2_pbot", {rec_pb[0], rec_pb[1], rec_pb[2]},
          {3'd0, 3'd0, 3'd1});
      chk("t2_fl", {rec_fst[1], rec_lst[1]}, 3);

      // T3: innerproduct, 4 ic, 2 oc, pad ignored
      send_cfg(1, 3, 1, 5, 2, 2, 1);
      run_layer(0, 1'b0, 300);
      chk("t3_done", n_done, 1);
      chk("t3_nrs", n_rs, 8);
      chk("t3_nwb", n_wb, 2);
      agg = '0;
      for (int i = 0; i < 8; i++)
         agg = agg | rec_idx[i] | LW'(rec_pt[i])
                   | LW'(rec_pb[i]);
      chk("t3_idx_pad0", agg, 0);
      chk("t3_first", {rec_fst[0], rec_fst[1],
                       rec_fst[4]}, 3'b101);
      chk("t3_last", {rec_lst[2], rec_lst[3],
                      rec_lst[7]}, 3'b011);
      chk("t3_oc", {rec_oc[3], rec_oc[4]},
          {10'd0, 10'd1});
      chk("t3_ic3", rec_ic[3], 3);

      // T4: norm (ic collapsed), slow wb, spurious done
      send_cfg(2, 3, 0, 1, 1, 0, 0);
      run_layer(10, 1'b1, 300);
      chk("t4_done", n_done, 1);
      chk("t4_nrs", n_rs, 1);
      chk("t4_nwb", n_wb, 1);
      chk("t4_wbcyc", n_wbcyc, 11);
      chk("t4_clash", n_clash, 0);
      chk("t4_fl", {rec_fst[0], rec_lst[0]}, 3);
      chk("t4_ic", rec_ic[0], 0);

      // T5: reserved layer type
      send_cfg(3, 1, 1, 3, 1, 0, 1);
      run_layer(0, 1'b0, 3);
      chk("t5_done", n_done, 1);
      chk("t5_nrs", n_rs, 0);
      chk("t5_err", cfg_err, 1);
      step();
      chk("t5_err_hold", {cfg_err, cfg_ready}, 3);

      // T6: reset while waiting for row_done
      send_cfg(0, 1, 1, 3, 1, 0, 1);
      chk("t6_err_clr", cfg_err, 0);
      step();
      chk("t6_issue", row_start, 1);
      step();
      chk("t6_wait", {row_start, row_first_ic}, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctl",
          {cfg_ready, row_start, wb_req, layer_done,
           row_first_ic, row_last_ic, cfg_err},
          7'b1000000);
      chk("t6_rst_row",
          {row_oc, row_ic, row_idx,
           row_pad_top, row_pad_bot}, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      send_cfg(0, 1, 1, 3, 1, 0, 1);
      run_layer(1, 1'b0, 600);
      chk("t6_done", n_done, 1);
      chk("t6_nrs", n_rs, 12);
      chk("t6_nwb", n_wb, 6);
      chk("t6_wbcyc", n_wbcyc, 12);
      chk("t6_oc", {rec_oc[0], rec_oc[5], rec_oc[6]},
          {10'd0, 10'd0, 10'd1});
      chk("t6_idx6", rec_idx[6], 0);

      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
